// File: rtl/ccff_loader_pkg.sv
// Shared state encoding, sizing helpers and defaults for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int DEF_CHAIN_LEN = 65;
    localparam int DEF_WORD_W    = 8;

    function automatic int words_for(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_CHAIN_LEN);

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host/chain-side bundle of the loader: start/verify control, word handshake, serial chain pins and status.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              verify;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, verify, word_data, word_valid, ccff_tail,
        input  word_ready, ccff_head, ccff_clk_en, busy, done, error
    );

    modport slave (
        input  start, verify, word_data, word_valid, ccff_tail,
        output word_ready, ccff_head, ccff_clk_en, busy, done, error
    );
endinterface

// File: rtl/ccff_word_serializer.sv
// WORD_W-bit PISO: load replaces contents (wins over shift), shift drops bit 0; one bit per shift, no stall of its own.
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bits,
    input  logic              shift,
    output logic              bit_out,
    output logic              has_bit,
    output logic              last_bit
);
    logic [WORD_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= load_data;
            cnt_q  <= load_bits;
        end else if (shift && (cnt_q != '0)) begin
            data_q <= {1'b0, data_q[WORD_W-1:1]};
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign bit_out  = data_q[0];
    assign has_bit  = (cnt_q != '0);
    assign last_bit = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host words onto ccff_head, gating prog_clk via ccff_clk_en; first bit two edges after word accept.
// Stalls (clk_en=0, head held) when no bit is buffered; CCFF_LOADER_READBACK_EN adds ccff_tail verify.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 65,
    parameter int WORD_W    = 8
) (
    input  logic prog_clk,
    input  logic pReset,
    ccff_chain_loader_if.slave bus
);
    localparam int N_WORDS   = words_for(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
    localparam int BIT_CNT_W = cnt_width(CHAIN_LEN);
    localparam int WL_W      = $clog2(N_WORDS + 1);
    localparam int SC_W      = $clog2(WORD_W + 1);

    localparam logic [BIT_CNT_W-1:0] LEN_C  = BIT_CNT_W'(CHAIN_LEN);
    localparam logic [WL_W-1:0]      NW_C   = WL_W'(N_WORDS);
    localparam logic [SC_W-1:0]      FULL_C = SC_W'(WORD_W);
    localparam logic [SC_W-1:0]      LAST_C = SC_W'(LAST_BITS);

    logic [1:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [WL_W-1:0]      words_left;
    logic                 head_q;
    logic                 en_q;

    logic                 ser_bit;
    logic                 ser_has;
    logic                 ser_last;
    logic                 shift_now;
    logic                 accept;
    logic                 start_acc;
    logic [SC_W-1:0]      load_bits;

    assign start_acc = (state == ST_IDLE) && bus.start;
    assign shift_now = (state == ST_LOAD) && ser_has && (bit_cnt < LEN_C);

    // Refill on the very edge the last buffered bit leaves, so words stream without a bubble.
    assign bus.word_ready = (state == ST_LOAD) && (words_left != '0) &&
                            (!ser_has || (ser_last && shift_now));
    assign accept    = bus.word_ready && bus.word_valid;
    assign load_bits = (words_left == WL_W'(1)) ? LAST_C : FULL_C;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (SC_W)
    ) u_ser (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .load      (accept),
        .load_data (bus.word_data),
        .load_bits (load_bits),
        .shift     (shift_now),
        .bit_out   (ser_bit),
        .has_bit   (ser_has),
        .last_bit  (ser_last)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            words_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_LOAD;
                        bit_cnt    <= '0;
                        words_left <= NW_C;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        words_left <= words_left - 1'b1;
                    end
                    if (shift_now) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // Leave only once the final shift's clk_en cycle has been presented.
                    if (bit_cnt == LEN_C) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            head_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            en_q <= shift_now;
            if (shift_now) begin
                head_q <= ser_bit;
            end
        end
    end

    assign bus.ccff_head   = head_q;
    assign bus.ccff_clk_en = en_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);

`ifdef CCFF_LOADER_READBACK_EN
    logic verify_q;
    logic error_q;

    // The bit on ccff_head is the one the tail should be returning on the same shift.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            verify_q <= 1'b0;
            error_q  <= 1'b0;
        end else if (start_acc) begin
            verify_q <= bus.verify;
            error_q  <= 1'b0;
        end else if (en_q && verify_q && (bus.ccff_tail != head_q)) begin
            error_q <= 1'b1;
        end
    end

    assign bus.error = error_q;
`else
    logic unused_inputs;
    assign unused_inputs = bus.verify ^ bus.ccff_tail ^ start_acc;
    assign bus.error     = 1'b0;
`endif

endmodule
